gemm_drain: RTL and testbench

Result drain for the GEMM systolic array. On a capture pulse it snapshots the full MxN accumulator grid, so the array can be cleared and restarted at once. It then streams the snapshot out one row per beat over a valid/ready interface. Each element is requantized from ACC_W to OUT_W by arithmetic right shift with round-half-up and saturation. The block sits between the array's accumulator outputs and the writeback/SRAM path.

---
 rtl/gemm_pkg.sv | 15 +
 rtl/gemm_drain_requant_sat.sv | 30 +++
 rtl/gemm_drain.sv | 116 +++++++++++
 tb/tb_gemm_drain.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and default dimensions for the GEMM result drain.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } drain_state_t;

    localparam int GEMM_M     = 16;
    localparam int GEMM_N     = 16;
    localparam int GEMM_ACC_W = 32;
    localparam int GEMM_OUT_W = 8;

endpackage

// File: rtl/gemm_drain_requant_sat.sv
// One requant lane: arithmetic right shift with round-half-up, then saturate to OUT_W.
module requant_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int SH_W  = $clog2(ACC_W)
) (
    input  logic signed [ACC_W-1:0] i_x,
    input  logic        [SH_W-1:0]  i_sh,
    output logic signed [OUT_W-1:0] o_y
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    // One guard bit so x + 2^(sh-1) never wraps; a zero shift adds nothing and passes x through.
    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_shf;

    assign w_ext = {i_x[ACC_W-1], i_x};
    assign w_rnd = (i_sh == '0) ? '0 : ((ACC_W+1)'(1) << (i_sh - 1'b1));
    assign w_shf = (w_ext + w_rnd) >>> i_sh;

    always_comb begin
        o_y = w_shf[OUT_W-1:0];
        if (w_shf > SAT_MAX)      o_y = SAT_MAX[OUT_W-1:0];
        else if (w_shf < SAT_MIN) o_y = SAT_MIN[OUT_W-1:0];
    end

endmodule

// File: rtl/gemm_drain.sv
// Snapshots the MxN accumulator grid on capture and streams it out one requantized row per beat.
module gemm_drain
    import gemm_pkg::*;
#(
    parameter int M     = GEMM_M,
    parameter int N     = GEMM_N,
    parameter int ACC_W = GEMM_ACC_W,
    parameter int OUT_W = GEMM_OUT_W,
    parameter int SH_W  = $clog2(ACC_W)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  capture,
    input  logic                                  abort,
    input  logic        [SH_W-1:0]                shift_amt,
    input  logic signed [M-1:0][N-1:0][ACC_W-1:0] acc_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [N-1:0][OUT_W-1:0]        out_row,
    output logic        [$clog2(M)-1:0]           out_row_idx,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  capture_err
);

    localparam int RW = $clog2(M);

    drain_state_t                   r_state;
    logic [M-1:0][N-1:0][ACC_W-1:0] r_snap;
    logic [SH_W-1:0]                r_sh;
    logic [RW-1:0]                  r_row_ptr;
    logic                           r_valid;
    logic [N-1:0][OUT_W-1:0]        r_row;
    logic                           r_done;
    logic                           r_err;

    logic                           w_hs;
    logic                           w_last_ptr;
    logic [RW-1:0]                  w_sel;
    logic [N-1:0][OUT_W-1:0]        w_rq;

    assign w_hs       = r_valid && out_ready;
    assign w_last_ptr = (r_row_ptr == RW'(M-1));
    // Lanes always look at the row that goes out next: row 0 in LOAD, row_ptr+1 while streaming.
    assign w_sel      = (r_state == STREAM && !w_last_ptr) ? r_row_ptr + 1'b1 : '0;

    for (genvar g = 0; g < N; g++) begin : g_lane
        requant_sat #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W),
            .SH_W  (SH_W)
        ) u_rq (
            .i_x  (r_snap[w_sel][g]),
            .i_sh (r_sh),
            .o_y  (w_rq[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_sh      <= '0;
            r_row_ptr <= '0;
            r_valid   <= 1'b0;
            r_row     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_valid   <= 1'b0;
                r_row_ptr <= '0;
            end else begin
                if (capture && r_state != IDLE) r_err <= 1'b1;
                case (r_state)
                    IDLE: if (capture) begin
                        r_snap    <= acc_in;
                        r_sh      <= shift_amt;
                        r_row_ptr <= '0;
                        r_state   <= LOAD;
                    end
                    LOAD: begin
                        r_row   <= w_rq;
                        r_valid <= 1'b1;
                        r_state <= STREAM;
                    end
                    STREAM: if (w_hs) begin
                        if (w_last_ptr) begin
                            r_valid   <= 1'b0;
                            r_done    <= 1'b1;
                            r_row_ptr <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_row_ptr <= r_row_ptr + 1'b1;
                            r_row     <= w_rq;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_row     = r_row;
    assign out_row_idx = r_row_ptr;
    assign out_last    = r_valid && w_last_ptr;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign capture_err = r_err;

endmodule

// File: tb/tb_gemm_drain.sv
// Directed bench for gemm_drain: transaction-level drain model compared every cycle, plus literal pins.
module tb_gemm_drain;

    localparam int M     = 16;
    localparam int N     = 16;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int SH_W  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic capture = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;
    logic [SH_W-1:0] shift_amt = '0;
    logic signed [M-1:0][N-1:0][ACC_W-1:0] acc_in = '0;
    logic out_valid, out_last, busy, done, capture_err;
    logic signed [N-1:0][OUT_W-1:0] out_row;
    logic [3:0] out_row_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int h0, d0;
    bit chk_en = 1'b0;

    // Model state: what has been captured and where the consumer is in the drain.
    int  m_grid [M][N];
    int  m_sh = 0;
    bit  m_active = 0, m_valid = 0, m_pend = 0, m_done = 0, m_err = 0;
    int  m_idx = 0;
    bit  was_busy;
    logic [N-1:0][OUT_W-1:0] er;

    gemm_drain #(.M(M), .N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
        .clk(clk), .rst_n(rst_n), .capture(capture), .abort(abort), .shift_amt(shift_amt),
        .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done),
        .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    // Round-half-up as floor((x + d/2) / d), then clamp.
    function automatic int rq_model(input longint x, input int sh);
        longint d, num, q;
        if (sh == 0) q = x;
        else begin
            d = longint'(1) << sh;
            num = x + d / 2;
            q = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (q > (1 << (OUT_W-1)) - 1) q = (1 << (OUT_W-1)) - 1;
        if (q < -(1 << (OUT_W-1))) q = -(1 << (OUT_W-1));
        return int'(q);
    endfunction

    task automatic chki(input string nm, input longint a, input longint e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [N*OUT_W-1:0] a, input logic [N*OUT_W-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_valid = 0; m_pend = 0; m_done = 0; m_err = 0; m_idx = 0;
        end else begin
            was_busy = m_active;
            m_done = 0;
            m_err = 0;
            if (abort) begin
                m_active = 0; m_valid = 0; m_pend = 0; m_idx = 0;
            end else begin
                if (capture && was_busy) m_err = 1;
                if (m_valid && out_ready) begin
                    if (m_idx == M-1) begin
                        m_valid = 0; m_active = 0; m_done = 1; m_idx = 0;
                    end else m_idx++;
                end else if (m_pend) begin
                    m_pend = 0; m_valid = 1;
                end
                if (capture && !was_busy) begin
                    for (int i = 0; i < M; i++)
                        for (int j = 0; j < N; j++) m_grid[i][j] = acc_in[i][j];
                    m_sh = int'(shift_amt);
                    m_active = 1; m_pend = 1; m_idx = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chki("busy", busy, m_active);
            chki("out_valid", out_valid, m_valid);
            chki("done", done, m_done);
            chki("capture_err", capture_err, m_err);
            chki("out_last", out_last, m_valid && m_idx == M-1);
            if (m_valid || !rst_n) begin
                chki("out_row_idx", out_row_idx, m_idx);
                for (int j = 0; j < N; j++)
                    er[j] = rst_n ? OUT_W'(rq_model(m_grid[m_idx][j], m_sh)) : '0;
                chkv("out_row", out_row, er);
            end
            if (rst_n && out_valid && out_ready && !abort) hs_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int mul);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) acc_in[i][j] = ACC_W'(base + mul * i + j);
    endtask

    task automatic start_drain(input int sh, input logic rdy);
        h0 = hs_cnt;
        d0 = done_cnt;
        shift_amt = SH_W'(sh);
        out_ready = rdy;
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic finish_drain(input bit bp);
        int k = 0;
        while ((busy || out_valid) && k < 200) begin
            out_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            tick();
            k++;
        end
        chki("drain_finished_in_time", k < 200, 1);
        tick();
        chki("rows_accepted", hs_cnt - h0, M);
        chki("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic wait_idx(input int idx);
        int k = 0;
        while (!(out_valid && out_row_idx == 4'(idx)) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_row: row %0d not presented, required within 100 cycles", idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        tick();
        chki("reset_busy", busy, 0);
        chkv("reset_out_row", out_row, '0);
        tick();
        rst_n = 1'b1;
        tick();

        chki("rq 24>>4", rq_model(24, 4), 2);
        chki("rq -24>>4", rq_model(-24, 4), -1);
        chki("rq 8>>4", rq_model(8, 4), 1);
        chki("rq -8>>4", rq_model(-8, 4), 0);
        chki("rq 5000>>4", rq_model(5000, 4), 127);
        chki("rq -5000>>4", rq_model(-5000, 4), -128);

        // Identity drain with cycle positions relative to the capture edge t.
        fill(0, 4);
        start_drain(0, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        chki("row0_cycle", 1 + n, 2);
        chki("row0_elem3", int'($signed(out_row[3])), 3);
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chki("done_cycle", 2 + n, 18);
        tick();
        chki("id_rows_accepted", hs_cnt - h0, M);
        chki("id_done_pulses", done_cnt - d0, 1);

        // Rounding and saturation, held under backpressure.
        acc_in = '0;
        acc_in[0][0] = 24;    acc_in[0][1] = -24;
        acc_in[0][2] = 8;     acc_in[0][3] = -8;
        acc_in[0][4] = 5000;  acc_in[0][5] = -5000;
        start_drain(4, 1'b0);
        wait_idx(0);
        chki("rnd 24", int'($signed(out_row[0])), 2);
        chki("rnd -24", int'($signed(out_row[1])), -1);
        chki("rnd 8", int'($signed(out_row[2])), 1);
        chki("rnd -8", int'($signed(out_row[3])), 0);
        chki("sat 5000", int'($signed(out_row[4])), 127);
        chki("sat -5000", int'($signed(out_row[5])), -128);
        tick();
        tick();
        finish_drain(1'b0);

        fill(-300, 40);
        start_drain(2, 1'b1);
        finish_drain(1'b1);

        // Array cleared to -1 right after capture must not leak into the drain.
        fill(-1000, 150);
        start_drain(0, 1'b1);
        acc_in = '1;
        finish_drain(1'b0);

        fill(5, 3);
        start_drain(1, 1'b1);
        wait_idx(5);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chki("busy_capture_err", capture_err, 1);
        finish_drain(1'b0);

        fill(-7, 2);
        start_drain(0, 1'b1);
        wait_idx(15);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chki("last_hs_capture_err", capture_err, 1);
        chki("last_hs_done", done, 1);
        tick();
        chki("no_restart_busy", busy, 0);
        tick();
        chki("no_restart_valid", out_valid, 0);
        chki("last_hs_rows", hs_cnt - h0, M);
        chki("last_hs_done_pulses", done_cnt - d0, 1);

        fill(11, 5);
        start_drain(0, 1'b1);
        wait_idx(7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chki("abort_valid", out_valid, 0);
        chki("abort_busy", busy, 0);
        tick();
        chki("abort_rows", hs_cnt - h0, 7);
        chki("abort_no_done", done_cnt - d0, 0);
        fill(-50, 6);
        start_drain(3, 1'b1);
        finish_drain(1'b1);

        fill(20, 1);
        start_drain(0, 1'b1);
        wait_idx(4);
        rst_n = 1'b0;
        tick();
        chki("rst_mid_valid", out_valid, 0);
        chki("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chki("rst_mid_no_done", done_cnt - d0, 0);
        fill(30, -4);
        start_drain(0, 1'b1);
        finish_drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
